// File: rtl/tmr_irq_controller.sv
// -----------------------------------------------------------------------------
// tmr_irq_controller
//
// Interrupt front end for the dual-unit 8-bit timer. The timer's twelve
// interrupt lines are edge-detected and latched into pending flags. A software
// enable mask selects which pending flags may interrupt the CPU. One request
// at a time goes out, always the lowest-numbered enabled pending source, with
// a req/ack handshake.
//
// Ports
//   clk_i         system clock, shared with the timer
//   rst_i         asynchronous, active-high reset
//   irq_src_i     raw timer interrupts:
//                   [0]CMIA0 [1]CMIA1 [2]CMIB0  [3]CMIB1  [4]OVI0  [5]OVI1
//                   [6]CMIA2 [7]CMIA3 [8]CMIB2  [9]CMIB3 [10]OVI2 [11]OVI3
//   mask_wr_i     write strobe for the enable mask
//   mask_wdata_i  new enable mask (1 = enabled)
//   mask_o        current enable mask
//   pending_o     latched pending flags, shown without the mask applied
//   irq_req_o     registered request to the CPU
//   irq_vec_o     index of the source being requested
//   irq_ack_i     CPU acknowledge, single-cycle pulse
//
// FSM
//   state | meaning
//   IDLE  | no request out; picks the next enabled pending source
//   REQ   | request held with a stable vector until acked
//   GAP   | one cycle with the request low before the next one
// -----------------------------------------------------------------------------
module tmr_irq_controller #(
  parameter int unsigned           NUM_SRC   = 12,
  parameter int unsigned           VEC_WIDTH = 4,
  parameter logic [NUM_SRC-1:0]    MASK_INIT = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_SRC-1:0]   irq_src_i,
  input  logic                 mask_wr_i,
  input  logic [NUM_SRC-1:0]   mask_wdata_i,
  output logic [NUM_SRC-1:0]   mask_o,
  output logic [NUM_SRC-1:0]   pending_o,
  output logic                 irq_req_o,
  output logic [VEC_WIDTH-1:0] irq_vec_o,
  input  logic                 irq_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic                 req_q, req_d;
  logic [VEC_WIDTH-1:0] vec_q, vec_d;

  logic [NUM_SRC-1:0]   src_edge;
  logic [NUM_SRC-1:0]   active;
  logic [NUM_SRC-1:0]   ack_clr;
  logic [VEC_WIDTH-1:0] first_idx;

  // Rising edges only; a line held high is counted once.
  assign src_edge = irq_src_i & ~src_q;
  assign active   = pending_q & mask_q;

  // Lowest set index wins, so scan from the top and let lower bits overwrite.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        first_idx = VEC_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (|active) begin
          vec_d   = first_idx;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Vector is frozen here: mask changes or higher-priority arrivals
        // do not withdraw a request the CPU may already be handling.
        if (irq_ack_i) begin
          ack_clr = {{(NUM_SRC-1){1'b0}}, 1'b1} << vec_q;
          req_d   = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A fresh edge on the bit being acked keeps it pending (set wins).
  assign pending_d = (pending_q & ~ack_clr) | src_edge;
  assign mask_d    = mask_wr_i ? mask_wdata_i : mask_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // All ones so a line already high at reset release is not an edge.
      src_q     <= '1;
      pending_q <= '0;
      mask_q    <= MASK_INIT;
      state_q   <= IDLE;
      req_q     <= 1'b0;
      vec_q     <= '0;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      req_q     <= req_d;
      vec_q     <= vec_d;
    end
  end

  assign mask_o    = mask_q;
  assign pending_o = pending_q;
  assign irq_req_o = req_q;
  assign irq_vec_o = vec_q;

endmodule
